onchip_ram_pipelined: RTL

ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

---
 rtl/onchip_ram_pipelined.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with an Avalon-MM slave face, pipelined reads (1 or 2 cycles),
// byte-lane writes, global clock enable and an optional zero-fill after reset.
// Optional per-byte even parity is built when ONCHIP_RAM_PARITY_EN is defined; otherwise
// readerror is tied low and inject_parity_err is ignored.
module onchip_ram_pipelined #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 12288,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  input  logic                inject_parity_err,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                readerror,
  output logic                init_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {StInit, StReady} state_e;

  state_e             r_state;
  logic [IDX_W-1:0]   r_init_addr;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               w_in_range;
  logic [IDX_W-1:0]   w_idx;
  logic               w_init_we;
  logic               w_acc;
  logic               w_wr_en;
  logic               w_rd_acc;
  logic [DATA_W-1:0]  w_word;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_rd_err;

  assign w_in_range  = {1'b0, address} < DEPTH_L;
  assign w_idx       = address[IDX_W-1:0];
  assign w_init_we   = (r_state == StInit) && (CLEAR_ON_RESET != 0);
  assign waitrequest = (r_state == StInit) || !clken;
  assign init_busy   = w_init_we;
  assign w_acc       = chipselect && (read || write) && !waitrequest;
  assign w_wr_en     = w_acc && write && w_in_range;
  // Read and write together performs the write only
  assign w_rd_acc    = w_acc && read && !write;
  // Combinational read sampled at the write edge, so same-cycle writes return old data
  assign w_word      = r_mem[w_idx];
  assign w_rd_data   = w_in_range ? w_word : '0;

  // Init FSM: zero-fill walks the address space once, then the slave goes ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StInit;
      r_init_addr <= '0;
    end else begin
      case (r_state)
        StInit: begin
          if ((CLEAR_ON_RESET == 0) || (r_init_addr == IDX_W'(DEPTH - 1))) begin
            r_state <= StReady;
          end else begin
            r_init_addr <= r_init_addr + 1'b1;
          end
        end
        default: r_state <= StReady;
      endcase
    end
  end

`ifdef ONCHIP_RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];

  // Flag any byte lane selected by byteenable whose stored parity disagrees
  always_comb begin
    w_rd_err = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (byteenable[b] && ((^w_word[b*8 +: 8]) != r_par[w_idx][b])) begin
        w_rd_err = 1'b1;
      end
    end
    if (!w_in_range) begin
      w_rd_err = 1'b0;
    end
  end
`else
  logic w_unused_inject;
  assign w_unused_inject = inject_parity_err;
  assign w_rd_err        = 1'b0;
`endif

  // Storage: zero-fill during init, byte-lane writes once ready (no reset on the array)
  always_ff @(posedge clk) begin
    if (w_init_we) begin
      r_mem[r_init_addr] <= '0;
`ifdef ONCHIP_RAM_PARITY_EN
      r_par[r_init_addr] <= '0;
`endif
    end else if (w_wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (byteenable[b]) begin
          r_mem[w_idx][b*8 +: 8] <= writedata[b*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
          r_par[w_idx][b] <= (^writedata[b*8 +: 8]) ^ inject_parity_err;
`endif
        end
      end
    end
  end

  logic              w_s_v;
  logic              w_s_e;
  logic [DATA_W-1:0] w_s_d;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              r_p_v;
      logic              r_p_e;
      logic [DATA_W-1:0] r_p_d;

      // Extra read stage, frozen with the rest of the pipe while clken is low
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_p_v <= 1'b0;
          r_p_e <= 1'b0;
          r_p_d <= '0;
        end else if (clken) begin
          r_p_v <= w_rd_acc;
          r_p_e <= w_rd_acc && w_rd_err;
          r_p_d <= w_rd_data;
        end
      end

      assign w_s_v = r_p_v;
      assign w_s_e = r_p_e;
      assign w_s_d = r_p_d;
    end else begin : g_lat1
      assign w_s_v = w_rd_acc;
      assign w_s_e = w_rd_err;
      assign w_s_d = w_rd_data;
    end
  endgenerate

  logic              r_rdv;
  logic              r_rerr;
  logic [DATA_W-1:0] r_out_d;
  logic [DATA_W-1:0] r_hold;

  // Output stage; r_hold keeps the last delivered word so readdata is stable between beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdv   <= 1'b0;
      r_rerr  <= 1'b0;
      r_out_d <= '0;
      r_hold  <= '0;
    end else begin
      if (readdatavalid) begin
        r_hold <= r_out_d;
      end
      if (clken) begin
        r_rdv  <= w_s_v;
        r_rerr <= w_s_v && w_s_e;
        if (w_s_v) begin
          r_out_d <= w_s_d;
        end
      end
    end
  end

  // A pending beat is only presented in an enabled cycle, which is when it is consumed
  assign readdatavalid = r_rdv && clken;
  assign readerror     = r_rerr && readdatavalid;
  assign readdata      = readdatavalid ? r_out_d : r_hold;

endmodule
